// File: rtl/tpu_package.sv
// rtl/tpu_package.sv - shared sizes, row type and sender state encoding
//
// Purpose : constants and types shared by the weight tile sender and its row storage.
// Contents: MUL_SIZE (rows per tile and weights per row), W_WIDTH (weight MSB index),
//           WSEND_DEPTH / WSEND_AW (row storage size), w_row_t, wsend_state_t.
package tpu_package;

    localparam int MUL_SIZE    = 4;
    localparam int W_WIDTH     = 7;
    localparam int WSEND_DEPTH = 256;
    localparam int WSEND_AW    = 8;
    localparam int ROW_CNT_W   = $clog2(MUL_SIZE);

    typedef logic [MUL_SIZE-1:0][W_WIDTH:0] w_row_t;

    typedef enum logic [2:0] {
        WS_IDLE,
        WS_WAIT_REQ,
        WS_FETCH,
        WS_SEND,
        WS_DONE
    } wsend_state_t;

endpackage

// File: rtl/weight_row_ram.sv
// rtl/weight_row_ram.sv - simple dual-port weight row storage, registered read
//
// Purpose : one write port, one read port with a single-cycle registered read.
//           A same-cycle write to the row being read returns the old contents.
//           Contents are deliberately not reset.
// Ports   : clk_i              clock
//           wr_en_i/wr_addr_i/wr_data_i   write port
//           rd_en_i/rd_addr_i  read request; rd_data_o valid the following cycle
module weight_row_ram
    import tpu_package::*;
#(
    parameter int DEPTH  = WSEND_DEPTH,
    parameter int ADDR_W = WSEND_AW
) (
    input  logic                           clk_i,
    input  logic                           wr_en_i,
    input  logic [ADDR_W-1:0]              wr_addr_i,
    input  logic [MUL_SIZE-1:0][W_WIDTH:0] wr_data_i,
    input  logic                           rd_en_i,
    input  logic [ADDR_W-1:0]              rd_addr_i,
    output logic [MUL_SIZE-1:0][W_WIDTH:0] rd_data_o
);

    w_row_t mem [DEPTH];

    // Both updates are non-blocking, so the read sees the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/weight_tile_sender.sv
// rtl/weight_tile_sender.sv - streams tiles of weight rows from local storage to the weight FIFO
//
// Purpose : on start_i, sends num_tiles_i tiles of MUL_SIZE rows starting at base_addr_i,
//           one tile per request_i grant, with addresses wrapping modulo DEPTH.
// Ports   : clk_i, rst_i (async, active-low)
//           wr_en_i/wr_addr_i/wr_data_i   host row writes, accepted in any state
//           start_i/base_addr_i/num_tiles_i   transfer launch (sampled in IDLE only)
//           request_i                      FIFO has room for one tile
//           sending_o/data_o               row stream to the FIFO (data zero when idle)
//           busy_o                         high outside IDLE
//           done_o                         one-cycle completion pulse
module weight_tile_sender
    import tpu_package::*;
#(
    parameter int DEPTH  = WSEND_DEPTH,
    parameter int ADDR_W = WSEND_AW
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [ADDR_W-1:0]              wr_addr_i,
    input  logic [MUL_SIZE-1:0][W_WIDTH:0] wr_data_i,
    input  logic                           start_i,
    input  logic [ADDR_W-1:0]              base_addr_i,
    input  logic [7:0]                     num_tiles_i,
    input  logic                           request_i,
    output logic                           sending_o,
    output logic [MUL_SIZE-1:0][W_WIDTH:0] data_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam logic [ROW_CNT_W-1:0] ROW_LAST = ROW_CNT_W'(MUL_SIZE - 1);

    wsend_state_t         state_q, state_d;
    logic [7:0]           tiles_left_q, tiles_left_d;
    logic [ADDR_W-1:0]    tile_addr_q, tile_addr_d;
    logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;

    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    w_row_t               rd_data;

    weight_row_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_row_ram (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= WS_IDLE;
            tiles_left_q <= '0;
            tile_addr_q  <= '0;
            row_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            tiles_left_q <= tiles_left_d;
            tile_addr_q  <= tile_addr_d;
            row_cnt_q    <= row_cnt_d;
        end
    end

    // FETCH reads tile row 0; each SEND cycle presents row r (read last cycle)
    // while reading row r+1, so a tile streams without gaps.
    always_comb begin
        state_d      = state_q;
        tiles_left_d = tiles_left_q;
        tile_addr_d  = tile_addr_q;
        row_cnt_d    = row_cnt_q;
        rd_en        = 1'b0;
        rd_addr      = tile_addr_q;

        case (state_q)
            WS_IDLE: begin
                if (start_i) begin
                    tile_addr_d  = base_addr_i;
                    tiles_left_d = num_tiles_i;
                    row_cnt_d    = '0;
                    state_d      = (num_tiles_i == 8'd0) ? WS_DONE : WS_WAIT_REQ;
                end
            end
            WS_WAIT_REQ: begin
                if (request_i) begin
                    state_d = WS_FETCH;
                end
            end
            WS_FETCH: begin
                rd_en     = 1'b1;
                rd_addr   = tile_addr_q;
                row_cnt_d = '0;
                state_d   = WS_SEND;
            end
            WS_SEND: begin
                if (row_cnt_q == ROW_LAST) begin
                    row_cnt_d    = '0;
                    tiles_left_d = tiles_left_q - 8'd1;
                    // Address arithmetic is ADDR_W wide, so it wraps modulo DEPTH.
                    tile_addr_d  = tile_addr_q + ADDR_W'(MUL_SIZE);
                    state_d      = (tiles_left_q == 8'd1) ? WS_DONE : WS_WAIT_REQ;
                end else begin
                    rd_en     = 1'b1;
                    rd_addr   = tile_addr_q + ADDR_W'(row_cnt_q) + ADDR_W'(1);
                    row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
                end
            end
            WS_DONE: begin
                state_d = WS_IDLE;
            end
            default: begin
                state_d = WS_IDLE;
            end
        endcase
    end

    // Outputs decode the state register directly so reset clears them at once.
    assign sending_o = (state_q == WS_SEND);
    assign data_o    = sending_o ? rd_data : '0;
    assign busy_o    = (state_q != WS_IDLE);
    assign done_o    = (state_q == WS_DONE);

endmodule

// File: tb/tb_weight_tile_sender.sv
// tb/tb_weight_tile_sender.sv - self-checking bench for weight_tile_sender
module tb_weight_tile_sender;
    import tpu_package::*;

    localparam int DEPTH = WSEND_DEPTH;
    localparam int AW    = WSEND_AW;
    localparam int NCYC  = 2048;

    typedef logic [W_WIDTH:0] w_t;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            wr_en_i = 1'b0;
    logic [AW-1:0]   wr_addr_i = '0;
    w_row_t          wr_data_i = '0;
    logic            start_i = 1'b0;
    logic [AW-1:0]   base_addr_i = '0;
    logic [7:0]      num_tiles_i = '0;
    logic            request_i = 1'b0;
    logic            sending_o;
    w_row_t          data_o;
    logic            busy_o;
    logic            done_o;

    always #5 clk_i = ~clk_i;

    weight_tile_sender dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .num_tiles_i (num_tiles_i),
        .request_i   (request_i),
        .sending_o   (sending_o),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic w_row_t row_val(input int i);
        w_row_t v;
        for (int c = 0; c < MUL_SIZE; c++) v[c] = w_t'(i + 64 * c);
        return v;
    endfunction

    // Timeline model: interval e is the clock period following rising edge e.
    int     ecnt = 0;
    w_row_t mem_m     [DEPTH];
    bit     exp_send  [NCYC];
    int     exp_addr  [NCYC];
    w_row_t exp_data  [NCYC];
    bit     exp_busy  [NCYC];
    bit     exp_done  [NCYC];
    int     mode = 0;
    int     tiles_m = 0;
    int     addr_m = 0;
    int     next_req_edge = 0;
    int     done_edge = -1;
    int     idle_edge = 0;

    always @(posedge clk_i) begin
        int e;
        ecnt = ecnt + 1;
        e = ecnt;
        if (e < NCYC) begin
            if (!rst_i) begin
                mode = 0; idle_edge = 0; done_edge = -1;
                for (int i = e; i < NCYC && i < e + 16; i++) exp_send[i] = 0;
                exp_busy[e] = 0;
                exp_done[e] = 0;
                if (wr_en_i) mem_m[wr_addr_i] = wr_data_i;
            end else begin
                // a row read at this edge sees storage before this edge's write
                if (exp_send[e]) exp_data[e] = mem_m[exp_addr[e]];
                if (wr_en_i) mem_m[wr_addr_i] = wr_data_i;
                if (mode == 0) begin
                    if (e >= idle_edge && start_i) begin
                        mode = 1; tiles_m = num_tiles_i; addr_m = base_addr_i;
                        if (num_tiles_i == 0) done_edge = e;
                        else begin done_edge = -1; next_req_edge = e + 1; end
                    end
                end else if (done_edge < 0 && e >= next_req_edge && request_i) begin
                    for (int r = 0; r < MUL_SIZE; r++) begin
                        if (e + 1 + r < NCYC) begin
                            exp_send[e + 1 + r] = 1;
                            exp_addr[e + 1 + r] = (addr_m + r) % DEPTH;
                        end
                    end
                    tiles_m = tiles_m - 1;
                    addr_m  = (addr_m + MUL_SIZE) % DEPTH;
                    if (tiles_m == 0) done_edge = e + MUL_SIZE + 1;
                    else next_req_edge = e + MUL_SIZE + 2;
                end
                exp_busy[e] = (mode == 1);
                exp_done[e] = (mode == 1 && done_edge == e);
                if (mode == 1 && done_edge == e) begin
                    mode = 0; idle_edge = e + 2;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_i) begin
        int e;
        logic es, eb, ed;
        w_row_t edt;
        e = ecnt;
        if (e < NCYC) begin
            if (!rst_i) begin
                es = 0; eb = 0; ed = 0; edt = '0;
            end else begin
                es = exp_send[e]; eb = exp_busy[e]; ed = exp_done[e];
                edt = es ? exp_data[e] : '0;
            end
            chk("sending", 64'(sending_o), 64'(es));
            chk("data", 64'(data_o), 64'(edt));
            chk("busy", 64'(busy_o), 64'(eb));
            chk("done", 64'(done_o), 64'(ed));
        end
    end

    // Recorder for the literal expectations.
    w_row_t sent_q[$];
    int     first_send_iv = -1;
    int     done_cnt = 0;
    int     busy_cnt = 0;

    always @(negedge clk_i) begin
        if (sending_o) begin
            sent_q.push_back(data_o);
            if (first_send_iv < 0) first_send_iv = ecnt;
        end
        if (done_o) done_cnt++;
        if (busy_o) busy_cnt++;
    end

    task automatic clear_rec();
        sent_q.delete();
        first_send_iv = -1;
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input int base, input int n);
        start_i = 1'b1;
        base_addr_i = AW'(base);
        num_tiles_i = 8'(n);
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        int wrap_exp [4] = '{DEPTH - 2, DEPTH - 1, 0, 1};
        int req_iv;
        w_row_t newv;

        rst_i = 1'b1;
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_sending", 64'(sending_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        rst_i = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            wr_en_i = 1'b1; wr_addr_i = AW'(i); wr_data_i = row_val(i);
            tick();
        end
        wr_en_i = 1'b0;
        tick();

        // two tiles from row 0, request held high
        clear_rec();
        request_i = 1'b1;
        do_start(0, 2);
        repeat (25) tick();
        chk("a_nsend", 64'(sent_q.size()), 64'(2 * MUL_SIZE));
        for (int i = 0; i < sent_q.size() && i < 2 * MUL_SIZE; i++)
            chk("a_row", 64'(sent_q[i][0]), 64'(i));
        chk("a_done", 64'(done_cnt), 64'd1);
        chk("a_busy", 64'(busy_cnt), 64'(2 * MUL_SIZE + 5));

        // zero tiles
        clear_rec();
        request_i = 1'b0;
        do_start(0, 0);
        repeat (5) tick();
        chk("b_nsend", 64'(sent_q.size()), 64'd0);
        chk("b_done", 64'(done_cnt), 64'd1);
        chk("b_busy", 64'(busy_cnt), 64'd1);

        // wrap-around past the top of storage
        clear_rec();
        request_i = 1'b1;
        do_start(DEPTH - 2, 1);
        repeat (12) tick();
        chk("c_nsend", 64'(sent_q.size()), 64'(MUL_SIZE));
        for (int i = 0; i < sent_q.size() && i < 4; i++)
            chk("c_row", 64'(sent_q[i][0]), 64'(wrap_exp[i]));

        // delayed request, dropped mid-tile
        clear_rec();
        request_i = 1'b0;
        do_start(8, 1);
        repeat (10) tick();
        request_i = 1'b1;
        req_iv = ecnt;
        repeat (3) tick();
        request_i = 1'b0;
        repeat (10) tick();
        chk("d_latency", 64'(first_send_iv - req_iv), 64'd2);
        chk("d_nsend", 64'(sent_q.size()), 64'(MUL_SIZE));
        for (int i = 0; i < sent_q.size() && i < MUL_SIZE; i++)
            chk("d_row", 64'(sent_q[i][0]), 64'(8 + i));
        chk("d_done", 64'(done_cnt), 64'd1);

        // reset during the third SEND cycle
        clear_rec();
        request_i = 1'b1;
        do_start(0, 1);
        repeat (4) tick();
        #1 rst_i = 1'b0;
        #1;
        chk("e_sending", 64'(sending_o), 64'd0);
        chk("e_data", 64'(data_o), 64'd0);
        chk("e_busy", 64'(busy_o), 64'd0);
        chk("e_done", 64'(done_o), 64'd0);
        chk("e_partial", 64'(sent_q.size()), 64'd2);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        clear_rec();
        do_start(0, 1);
        repeat (10) tick();
        chk("e_nsend", 64'(sent_q.size()), 64'(MUL_SIZE));
        for (int i = 0; i < sent_q.size() && i < MUL_SIZE; i++)
            chk("e_row", 64'(sent_q[i][0]), 64'(i));

        // write row 5 in the same cycle its read is issued
        for (int c = 0; c < MUL_SIZE; c++) newv[c] = w_t'(8'hA5 + c);
        clear_rec();
        request_i = 1'b1;
        do_start(5, 1);
        tick();
        wr_en_i = 1'b1; wr_addr_i = AW'(5); wr_data_i = newv;
        tick();
        wr_en_i = 1'b0;
        repeat (8) tick();
        chk("f_nsend", 64'(sent_q.size()), 64'(MUL_SIZE));
        if (sent_q.size() > 0) chk("f_old", 64'(sent_q[0]), 64'(row_val(5)));
        clear_rec();
        do_start(5, 1);
        repeat (10) tick();
        if (sent_q.size() > 0) chk("f_new", 64'(sent_q[0]), 64'(newv));
        else chk("f_new_nsend", 64'(sent_q.size()), 64'(MUL_SIZE));

        request_i = 1'b0;
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
